// File: rtl/count_mon_pkg.sv
// count_mon_pkg
//   Shared types and default sizing for the count/PWM monitor slice.
//   mon_state_t    : monitor FSM state (ACQ, TRACK, ERR)
//   DEF_WIDTH      : default count / duty width
//   DEF_DUTY_RESET : default active duty after reset (50% at 8 bits)
//   DEF_WRAP_CNT_W : default saturating wrap counter width
package count_mon_pkg;

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } mon_state_t;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_DUTY_RESET = 128;
  localparam int unsigned DEF_WRAP_CNT_W = 16;

endpackage

// File: rtl/duty_shadow_reg.sv
// duty_shadow_reg
//   Single-entry pending slot fed by a valid/ready handshake, plus the active
//   duty register. The pending value moves to active only on the apply strobe.
//   clk, rst    : clock, synchronous active-high reset
//   duty_valid  : new duty offered
//   duty_data   : offered duty value
//   duty_ready  : pending slot empty
//   apply       : period boundary strobe
//   duty_next   : duty that is active from the next cycle on
module duty_shadow_reg
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DUTY_RESET = DEF_DUTY_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             duty_valid,
  input  logic [WIDTH-1:0] duty_data,
  output logic             duty_ready,
  input  logic             apply,
  output logic [WIDTH-1:0] duty_next
);

  localparam logic [WIDTH-1:0] DUTY_INIT = WIDTH'(DUTY_RESET);

  logic [WIDTH-1:0] pend;
  logic             pend_vld;
  logic [WIDTH-1:0] active;

  assign duty_ready = !pend_vld;

  // Look-ahead so the compare on the boundary cycle already uses the new
  // duty; otherwise the first cycle of a period would see the old value.
  assign duty_next = (apply && pend_vld) ? pend : active;

  // Apply and accept never coincide: accepting requires an empty slot, and
  // applying an empty slot is a no-op.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      pend_vld <= 1'b0;
      active   <= DUTY_INIT;
    end else begin
      if (apply && pend_vld) begin
        active   <= pend;
        pend_vld <= 1'b0;
      end
      if (duty_valid && duty_ready) begin
        pend     <= duty_data;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_pwm_monitor.sv
// count_pwm_monitor
//   Watches a free-running count bus: checks +1 sequencing, counts wraps and
//   drives a registered PWM from a duty value that only changes at wrap.
//   clk, rst    : clock, synchronous active-high reset
//   count       : counter value from the counter stage
//   duty_valid  : new duty offered      duty_data : duty value
//   duty_ready  : pending slot empty
//   clr_err     : leave ERR and re-acquire
//   pwm_out     : registered count < active duty (TRACK only)
//   wrap_pulse  : one-cycle pulse per detected wrap
//   wrap_cnt    : saturating wraps since lock
//   seq_err     : sticky sequence error
//   locked      : FSM in TRACK
module count_pwm_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DUTY_RESET = DEF_DUTY_RESET,
  parameter int unsigned WRAP_CNT_W = DEF_WRAP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count,
  input  logic                  duty_valid,
  input  logic [WIDTH-1:0]      duty_data,
  output logic                  duty_ready,
  input  logic                  clr_err,
  output logic                  pwm_out,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_cnt,
  output logic                  seq_err,
  output logic                  locked
);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_inc;
  logic             seq_ok;
  logic             wrap_det;
  logic [WIDTH-1:0] duty_next;

  assign cnt_inc  = cnt_q + WIDTH'(1);
  assign seq_ok   = (count == cnt_inc);
  assign wrap_det = (state == TRACK) && (cnt_q == '1) && (count == '0);
  assign locked   = (state == TRACK);

  duty_shadow_reg #(
    .WIDTH      (WIDTH),
    .DUTY_RESET (DUTY_RESET)
  ) u_duty (
    .clk        (clk),
    .rst        (rst),
    .duty_valid (duty_valid),
    .duty_data  (duty_data),
    .duty_ready (duty_ready),
    .apply      (wrap_det),
    .duty_next  (duty_next)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACQ:     state_nxt = TRACK;
      TRACK:   if (!seq_ok) state_nxt = ERR;
      ERR:     if (clr_err) state_nxt = ACQ;
      default: state_nxt = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    cnt_q <= count;
    if (rst) begin
      state      <= ACQ;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
      pwm_out    <= 1'b0;
    end else begin
      state      <= state_nxt;
      seq_err    <= (state_nxt == ERR);
      wrap_pulse <= wrap_det;
      pwm_out    <= (state == TRACK) && (count < duty_next);
      if (state == ERR && clr_err) begin
        wrap_cnt <= '0;
      end else if (wrap_det && wrap_cnt != '1) begin
        wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_pwm_monitor.sv
// tb_count_pwm_monitor
//   Directed stimulus drives the count bus and duty handshake; each expected
//   output is queued against the clock edge after which it must hold, and an
//   independent monitor compares on the falling edge.
module tb_count_pwm_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  count;
  logic        duty_valid;
  logic [7:0]  duty_data;
  logic        duty_ready;
  logic        clr_err;
  logic        pwm_out;
  logic        wrap_pulse;
  logic [15:0] wrap_cnt;
  logic        seq_err;
  logic        locked;

  always #5 clk = ~clk;

  count_pwm_monitor #(
    .WIDTH      (8),
    .DUTY_RESET (128),
    .WRAP_CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .duty_valid (duty_valid),
    .duty_data  (duty_data),
    .duty_ready (duty_ready),
    .clr_err    (clr_err),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .seq_err    (seq_err),
    .locked     (locked)
  );

  typedef enum int {F_PWM, F_WP, F_WC, F_ERR, F_LOCK, F_RDY} fld_t;
  typedef struct {
    int unsigned cyc;
    fld_t        f;
    int unsigned v;
    string       name;
  } chk_t;

  chk_t        sb[$];
  int unsigned edge_n   = 0;
  int unsigned mon_edge = 0;
  int unsigned total    = 0;
  int unsigned bad      = 0;
  logic [7:0]  cntv;

  function automatic int unsigned actual(input fld_t f);
    case (f)
      F_PWM:   return int'(pwm_out);
      F_WP:    return int'(wrap_pulse);
      F_WC:    return int'(wrap_cnt);
      F_ERR:   return int'(seq_err);
      F_LOCK:  return int'(locked);
      default: return int'(duty_ready);
    endcase
  endfunction

  always @(posedge clk) mon_edge <= mon_edge + 1;

  // Monitor: checks every queued expectation due after the latest edge.
  always @(negedge clk) begin
    int unsigned i;
    int unsigned a;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == mon_edge) begin
        a = actual(sb[i].f);
        total++;
        if (a != sb[i].v) begin
          bad++;
          $display("FAIL %s @edge %0d: got %0d want %0d", sb[i].name, mon_edge, a, sb[i].v);
        end
        sb.delete(i);
      end else if (sb[i].cyc < mon_edge) begin
        total++;
        bad++;
        $display("FAIL %s: check missed (due edge %0d)", sb[i].name, sb[i].cyc);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic want(input int unsigned k, input fld_t f, input int unsigned v, input string name);
    chk_t c;
    c.cyc  = edge_n + k;
    c.f    = f;
    c.v    = v;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // Drive the next count value for each of n edges.
  task automatic step_n(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      count = cntv;
      tick();
      cntv = cntv + 8'd1;
    end
  endtask

  task automatic want_reset(input string tag);
    want(0, F_PWM,  0, {tag, "_pwm"});
    want(0, F_WP,   0, {tag, "_wp"});
    want(0, F_WC,   0, {tag, "_wc"});
    want(0, F_ERR,  0, {tag, "_err"});
    want(0, F_LOCK, 0, {tag, "_lock"});
    want(0, F_RDY,  1, {tag, "_rdy"});
  endtask

  initial begin
    rst = 1'b1; count = '0; clr_err = 1'b0; duty_valid = 1'b0; duty_data = '0;
    cntv = 8'd0;
    tick(); tick();
    want_reset("rst0");
    rst = 1'b0;

    // Lock on an incrementing count
    step_n(3);                                   // samples 0,1,2
    want(0, F_LOCK, 1, "lock_3rd_edge");
    want(0, F_ERR,  0, "no_err_lock");
    want(0, F_PWM,  1, "pwm_cnt2");
    want(0, F_WC,   0, "wc_before_wrap");

    // Two wraps at default duty 128
    step_n(125);                                 // ..127
    want(0, F_PWM, 1, "pwm_127_d128");
    step_n(1);                                   // 128
    want(0, F_PWM, 0, "pwm_128_d128");
    step_n(127);                                 // ..255
    want(0, F_WP, 0, "wp_at_255");
    step_n(1);                                   // 0
    want(0, F_WP, 1, "wp_wrap1");
    want(0, F_WC, 1, "wc_wrap1");
    step_n(1);                                   // 1
    want(0, F_WP, 0, "wp_one_cycle");
    step_n(254);                                 // ..255
    step_n(1);                                   // 0
    want(0, F_WP,   1, "wp_wrap2");
    want(0, F_WC,   2, "wc_wrap2");
    want(0, F_ERR,  0, "no_err_wrap2");
    want(0, F_LOCK, 1, "lock_wrap2");

    // Duty 64 offered mid-period, applies at the next wrap
    step_n(99);                                  // ..99
    want(0, F_RDY, 1, "rdy_idle");
    duty_valid = 1'b1; duty_data = 8'd64;
    step_n(1);                                   // 100, accepted
    want(0, F_RDY, 0, "rdy_after_64");
    duty_valid = 1'b0;
    step_n(27);                                  // ..127
    want(0, F_PWM, 1, "pwm_127_pend64");
    step_n(1);                                   // 128
    want(0, F_PWM, 0, "pwm_128_pend64");
    step_n(127);                                 // ..255
    want(0, F_RDY, 0, "rdy_hold_pend64");
    step_n(1);                                   // 0, apply 64
    want(0, F_WC,  3, "wc_wrap3");
    want(0, F_RDY, 1, "rdy_after_apply64");
    want(0, F_PWM, 1, "pwm_0_d64");
    step_n(63);                                  // ..63
    want(0, F_PWM, 1, "pwm_63_d64");
    step_n(1);                                   // 64
    want(0, F_PWM, 0, "pwm_64_d64");

    // 32 then 200 back-to-back: 200 stalls until after the wrap
    duty_valid = 1'b1; duty_data = 8'd32;
    step_n(1);                                   // 65, 32 accepted
    want(0, F_RDY, 0, "rdy_after_32");
    duty_data = 8'd200;
    step_n(190);                                 // ..255, 200 stalled
    want(0, F_RDY, 0, "rdy_stall_200");
    want(0, F_PWM, 0, "pwm_255_d64");
    step_n(1);                                   // 0, apply 32
    want(0, F_WC,  4, "wc_wrap4");
    want(0, F_RDY, 1, "rdy_after_apply32");
    want(0, F_PWM, 1, "pwm_0_d32");
    step_n(1);                                   // 1, 200 accepted
    want(0, F_RDY, 0, "rdy_accept_200");
    duty_valid = 1'b0;
    step_n(30);                                  // ..31
    want(0, F_PWM, 1, "pwm_31_d32");
    step_n(1);                                   // 32
    want(0, F_PWM, 0, "pwm_32_d32");
    step_n(223);                                 // ..255
    want(0, F_RDY, 0, "rdy_hold_pend200");
    step_n(1);                                   // 0, apply 200
    want(0, F_WC,  5, "wc_wrap5");
    want(0, F_RDY, 1, "rdy_after_apply200");
    step_n(199);                                 // ..199
    want(0, F_PWM, 1, "pwm_199_d200");
    step_n(1);                                   // 200
    want(0, F_PWM, 0, "pwm_200_d200");

    // Reset with duty 16 pending and wrap_cnt=5
    duty_valid = 1'b1; duty_data = 8'd16;
    step_n(1);                                   // 201, 16 pending
    want(0, F_RDY, 0, "rdy_pend16");
    want(0, F_WC,  5, "wc5_before_rst");
    duty_valid = 1'b0;
    rst = 1'b1;
    step_n(1);
    want_reset("rst_mid");
    rst = 1'b0;
    cntv = 8'd0;
    step_n(128);                                 // 0..127
    want(0, F_PWM,  1, "pwm_127_after_rst");
    want(0, F_LOCK, 1, "relock_after_rst");
    step_n(1);                                   // 128
    want(0, F_PWM, 0, "pwm_128_after_rst");
    step_n(127);                                 // ..255
    want(0, F_RDY, 1, "rdy_pend_discarded");
    want(0, F_WC,  0, "wc_zero_after_rst");
    step_n(1);                                   // 0, nothing to apply
    want(0, F_WP, 1, "wp_after_rst");
    want(0, F_WC, 1, "wc1_after_rst");
    step_n(127);                                 // ..127
    want(0, F_PWM, 1, "pwm_127_still_d128");
    step_n(1);                                   // 128
    want(0, F_PWM, 0, "pwm_128_still_d128");

    // Duty boundaries: 0 and 255
    duty_valid = 1'b1; duty_data = 8'd0;
    step_n(1);                                   // 129
    want(0, F_RDY, 0, "rdy_pend0");
    duty_valid = 1'b0;
    step_n(126);                                 // ..255
    step_n(1);                                   // 0, apply 0
    want(0, F_PWM, 0, "pwm_0_d0");
    want(0, F_WC,  2, "wc_d0_wrap");
    step_n(1);                                   // 1
    want(0, F_PWM, 0, "pwm_1_d0");
    duty_valid = 1'b1; duty_data = 8'd255;
    step_n(1);                                   // 2
    want(0, F_RDY, 0, "rdy_pend255");
    duty_valid = 1'b0;
    step_n(253);                                 // ..255
    want(0, F_PWM, 0, "pwm_255_d0");
    step_n(1);                                   // 0, apply 255
    want(0, F_PWM, 1, "pwm_0_d255");
    want(0, F_WC,  3, "wc_d255_wrap");
    step_n(254);                                 // ..254
    want(0, F_PWM, 1, "pwm_254_d255");
    step_n(1);                                   // 255
    want(0, F_PWM, 0, "pwm_255_d255");

    // Sequence error 10 -> 12, then clear and relock
    step_n(10);                                  // 0..9
    want(0, F_WC,  4, "wc_before_err");
    want(0, F_PWM, 1, "pwm_9_d255");
    clr_err = 1'b1;
    step_n(1);                                   // 10, clr_err ignored in TRACK
    want(0, F_LOCK, 1, "clr_in_track_lock");
    want(0, F_ERR,  0, "clr_in_track_err");
    clr_err = 1'b0;
    cntv = 8'd12;
    step_n(1);                                   // 12
    want(0, F_ERR,  1, "err_on_jump");
    want(0, F_LOCK, 0, "unlock_on_jump");
    step_n(1);                                   // 13
    want(0, F_PWM,  0, "pwm_off_in_err");
    want(0, F_ERR,  1, "err_sticky");
    step_n(5);
    want(0, F_ERR, 1, "err_held");
    want(0, F_PWM, 0, "pwm_held_off");
    want(0, F_WC,  4, "wc_held_in_err");
    clr_err = 1'b1;
    step_n(1);                                   // -> ACQ
    want(0, F_ERR,  0, "err_cleared");
    want(0, F_LOCK, 0, "acq_unlocked");
    want(0, F_WC,   0, "wc_cleared");
    clr_err = 1'b0;
    step_n(1);                                   // -> TRACK
    want(0, F_LOCK, 1, "relock_after_clr");
    want(0, F_WC,   0, "wc_zero_relock");
    step_n(32'd256 - int'(cntv));                // ..255
    step_n(1);                                   // 0
    want(0, F_WC, 1, "wc_counts_after_relock");
    want(0, F_ERR, 0, "no_err_after_relock");

    step_n(3);
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: check never evaluated", sb[0].name);
      sb.delete(0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
